seq_div32: RTL

//   Multi-cycle unsigned 32-bit restoring divider; responder side of the datapath's

---
 rtl/seq_div32_if.sv | 23 ++
 rtl/seq_div32.sv | 91 +++++++++
 2 files changed

// File: rtl/seq_div32_if.sv
// Request/response bundle between the datapath (master) and the sequential divider (slave).
interface seq_div32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, WIDTH clocks per
// division, with a one-cycle done pulse and results held until the next completion.
module seq_div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_div32_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rs;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction carries an extra borrow bit so the shifted remainder never wraps.
  always_comb begin
    rs     = {r, q[WIDTH-1]};
    diff   = {1'b0, rs} - {2'b00, d};
    fits   = ~diff[WIDTH+1];
    r_next = fits ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      q               <= '0;
      d               <= '0;
      r               <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          if (bus.start) begin
            q   <= bus.dividend;
            d   <= bus.divisor;
            r   <= '0;
            cnt <= '0;
            if (bus.divisor == '0) begin
              state           <= FIN;
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          q   <= q_next;
          r   <= r_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state           <= FIN;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_next;
            bus.remainder   <= r_next;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule
